// File: rtl/instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory_loader
// Purpose  : Instruction-memory responder for the fetch stage. After reset it
//            takes the program as a byte stream, packs the bytes
//            little-endian into 32-bit words written upward from word 0, then
//            serves PC -> instruction fetches with one-cycle latency.
// Ports    : clock, reset          - clock, synchronous active-high reset
//            load_valid/byte/last  - boot byte stream in
//            load_ready            - a load byte can be taken this cycle
//            load_done             - load phase complete (level)
//            fetch_req/fetch_pc    - fetch request in
//            fetch_ready           - a fetch request can be taken
//            fetch_valid/instr/fault - registered fetch response
//            reload                - return to the load phase (IMEM_RELOAD_EN)
// Options  : IMEM_RELOAD_EN - adds the reload input; without it RUN is left
//            only through reset.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_memory_loader #(
  parameter int          DEPTH     = 63,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0040_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_done,
  input  logic        fetch_req,
  input  logic [63:0] fetch_pc,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_fault
`ifdef IMEM_RELOAD_EN
  ,
  input  logic        reload
`endif
);

  // Counter width must hold DEPTH itself (wr_ptr reaches DEPTH when full).
  localparam int          c_CW      = $clog2(DEPTH + 1);
  localparam int          c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] c_BYTES   = 64'(4 * DEPTH);
  localparam logic [c_CW-1:0] c_DEPTH_W = c_CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [c_CW-1:0]   r_wr_ptr;
  logic [c_CW-1:0]   r_word_count;
  logic [31:0]       r_partial;
  // Set on the cycle of the final write; the state moves to RUN one cycle
  // later, and load_ready is already low in between so no byte is lost.
  logic              r_fin;
  logic [31:0]       r_mem [DEPTH];

  logic              w_load_acc;
  logic              w_wr_en;
  logic [31:0]       w_word;
  logic [c_CW-1:0]   w_wr_ptr_nxt;
  logic              w_full_nxt;

  logic              w_fetch_acc;
  logic              w_below;
  logic [63:0]       w_offset;
  logic              w_fault;
  logic [c_CW-1:0]   w_index;
  logic              w_hit;
  logic [31:0]       w_rd;

  // ---------------------------------------------------------------- load path
  assign w_load_acc   = (r_state == ST_LOAD) && load_valid && load_ready;
  assign w_wr_en      = w_load_acc && ((r_byte_cnt == 2'd3) || load_last);
  assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
  assign w_full_nxt   = (w_wr_ptr_nxt == c_DEPTH_W);

  // Upper bytes of the partial register are always zero, so inserting the
  // current byte also zero-fills a short final word.
  always_comb begin
    w_word = r_partial;
    case (r_byte_cnt)
      2'd0:    w_word[7:0]   = load_byte;
      2'd1:    w_word[15:8]  = load_byte;
      2'd2:    w_word[23:16] = load_byte;
      default: w_word[31:24] = load_byte;
    endcase
  end

  // --------------------------------------------------------------- fetch path
  assign w_fetch_acc = fetch_req && fetch_ready;
  // Explicit unsigned compare: below-base addresses must not rely on the
  // subtraction wrapping to a large offset.
  assign w_below     = (fetch_pc < BASE_ADDR);
  assign w_offset    = fetch_pc - BASE_ADDR;
  assign w_fault     = (fetch_pc[1:0] != 2'b00) || w_below || (w_offset >= c_BYTES);
  assign w_index     = w_offset[c_CW+1:2];
  assign w_hit       = (w_index < r_word_count);
  assign w_rd        = r_mem[w_index[c_AW-1:0]];

  // Memory array: write-only from the load path, never cleared.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= w_word;
    end
  end

  // ------------------------------------------------------- control and outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_LOAD;
      r_byte_cnt   <= 2'd0;
      r_wr_ptr     <= '0;
      r_word_count <= '0;
      r_partial    <= 32'h0;
      r_fin        <= 1'b0;
      load_ready   <= 1'b1;
      load_done    <= 1'b0;
      fetch_ready  <= 1'b0;
      fetch_valid  <= 1'b0;
      fetch_instr  <= 32'h0;
      fetch_fault  <= 1'b0;
    end else begin
      // Response uses the word count of the accepting cycle, so a fetch
      // taken alongside a reload still sees the old program.
      fetch_valid <= w_fetch_acc;
      if (w_fetch_acc) begin
        fetch_fault <= w_fault;
        if (w_fault) begin
          fetch_instr <= 32'h0;
        end else if (w_hit) begin
          fetch_instr <= w_rd;
        end else begin
          fetch_instr <= NOP_WORD;
        end
      end

      if (r_state == ST_LOAD) begin
        if (r_fin) begin
          r_fin       <= 1'b0;
          r_state     <= ST_RUN;
          load_done   <= 1'b1;
          fetch_ready <= 1'b1;
        end else if (w_load_acc) begin
          if (w_wr_en) begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_word_count <= r_word_count + 1'b1;
            r_byte_cnt   <= 2'd0;
            r_partial    <= 32'h0;
            if (load_last || w_full_nxt) begin
              load_ready <= 1'b0;
              r_fin      <= 1'b1;
            end
          end else begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_partial  <= w_word;
          end
        end
      end else begin
`ifdef IMEM_RELOAD_EN
        if (reload) begin
          r_state      <= ST_LOAD;
          r_word_count <= '0;
          r_wr_ptr     <= '0;
          r_byte_cnt   <= 2'd0;
          r_partial    <= 32'h0;
          load_done    <= 1'b0;
          fetch_ready  <= 1'b0;
          load_ready   <= 1'b1;
        end
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_memory_loader
// Purpose  : Scoreboard bench for instruction_memory_loader. Expected fetch
//            responses are queued when requests are issued; a monitor pops
//            and compares whenever fetch_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_memory_loader;

  localparam int          DEPTH = 63;
  localparam logic [63:0] BASE  = 64'h0000_0000_0040_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        fetch_req;
  logic [63:0] fetch_pc;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
`ifdef IMEM_RELOAD_EN
  logic        reload;
`endif

  always #5 clock = ~clock;

  instruction_memory_loader dut (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault)
`ifdef IMEM_RELOAD_EN
    ,
    .reload      (reload)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];      // {fault, instr}
  logic [7:0]  mb[$];         // bytes the model believes are loaded
  logic [7:0]  stim[$];       // bytes for the next load sequence

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  function automatic logic [31:0] model_word(input int idx);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (4 * idx + k < mb.size()) w[8*k +: 8] = mb[4*idx + k];
    end
    return w;
  endfunction

  function automatic logic [32:0] model_fetch(input logic [63:0] pc);
    int words;
    int idx;
    words = (mb.size() + 3) / 4;
    if (pc[1:0] != 2'b00 || pc < BASE || (pc - BASE) >= 64'(4 * DEPTH))
      return {1'b1, 32'h0};
    idx = int'((pc - BASE) / 64'd4);
    if (idx < words) return {1'b0, model_word(idx)};
    return {1'b0, NOP};
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(negedge clock) begin : mon
    logic [32:0] e;
    if (fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got fetch_valid=1 instr=%0h expected no response", fetch_instr);
      end else begin
        e = exp_q.pop_front();
        chk("fetch_instr", 64'(fetch_instr), 64'(e[31:0]));
        chk("fetch_fault", 64'(fetch_fault), 64'(e[32]));
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // A fetch request issued in the reset cycle must never respond.
  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_byte  = 8'h0;
    fetch_req  = 1'b1;
    fetch_pc   = BASE;
`ifdef IMEM_RELOAD_EN
    reload     = 1'b0;
`endif
    tick();
    fetch_req = 1'b0;
    chk("rst_load_ready",  64'(load_ready),  64'd1);
    chk("rst_load_done",   64'(load_done),   64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_fetch_instr", 64'(fetch_instr), 64'd0);
    chk("rst_fetch_fault", 64'(fetch_fault), 64'd0);
    reset = 1'b0;
    mb.delete();
  endtask

  task automatic load_seq(input bit with_last, input bit gaps);
    int w;
    for (int i = 0; i < stim.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        tick();
      end
      load_valid = 1'b1;
      load_byte  = stim[i];
      load_last  = with_last && (i == stim.size() - 1);
      w = 0;
      while (load_ready !== 1'b1 && w < 8) begin
        tick();
        w++;
      end
      if (w == 8) begin
        total++;
        bad++;
        $display("FAIL load_ready_wait: got load_ready=%0b expected 1 within 8 cycles", load_ready);
      end
      tick();
      mb.push_back(stim[i]);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Called in the cycle after the final write.
  task automatic finish_load();
    chk("load_ready_end", 64'(load_ready), 64'd0);
    tick();
    chk("load_done_run",   64'(load_done),   64'd1);
    chk("fetch_ready_run", 64'(fetch_ready), 64'd1);
    chk("load_ready_run",  64'(load_ready),  64'd0);
  endtask

  task automatic fetch(input logic [63:0] pc);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    exp_q.push_back(model_fetch(pc));
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic fetch_exp(input logic [63:0] pc, input logic [32:0] e);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    exp_q.push_back(e);
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic drain();
    tick();
    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  function automatic logic [63:0] rand_pc();
    case ($urandom_range(0, 5))
      0, 1:    return BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
      2:       return BASE + 64'(4 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 3));
      3:       return BASE - 64'(4 * $urandom_range(1, 2000));
      4:       return BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 100));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1; load_valid = 1'b0; load_byte = 8'h0; load_last = 1'b0;
    fetch_req = 1'b0; fetch_pc = 64'h0;
`ifdef IMEM_RELOAD_EN
    reload = 1'b0;
`endif
    do_reset();

    // Fetch requests during LOAD are ignored.
    fetch_req = 1'b1;
    fetch_pc  = BASE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("load_phase_no_valid", 64'(fetch_valid), 64'd0);
    end
    fetch_req = 1'b0;

    // One full word with last.
    stim = '{8'h93, 8'h00, 8'h10, 8'h00};
    load_seq(1'b1, 1'b0);
    finish_load();
    fetch_exp(BASE,                 {1'b0, 32'h0010_0093});
    fetch_exp(64'h0000_0000_0040_0004, {1'b0, NOP});
    fetch_exp(64'h0000_0000_0040_0002, {1'b1, 32'h0});
    fetch_exp(64'h0000_0000_003F_FFFC, {1'b1, 32'h0});
    fetch_exp(64'h0000_0000_0040_00FC, {1'b1, 32'h0});
    fetch_exp(64'h0000_0000_0040_00F8, {1'b0, NOP});
    drain();

`ifdef IMEM_RELOAD_EN
    // Fetch in the reload cycle still sees the old program.
    fetch_req = 1'b1;
    fetch_pc  = BASE;
    reload    = 1'b1;
    exp_q.push_back({1'b0, 32'h0010_0093});
    tick();
    fetch_req = 1'b0;
    reload    = 1'b0;
    mb.delete();
    chk("reload_load_done",   64'(load_done),   64'd0);
    chk("reload_fetch_ready", 64'(fetch_ready), 64'd0);
    chk("reload_load_ready",  64'(load_ready),  64'd1);
    stim = '{8'h13, 8'h00, 8'h00, 8'h00};
    load_seq(1'b1, 1'b0);
    finish_load();
    fetch_exp(BASE, {1'b0, 32'h0000_0013});
    fetch(BASE + 64'd4);
    drain();
`endif

    // Partial word.
    do_reset();
    stim = '{8'h62, 8'h00};
    load_seq(1'b1, 1'b0);
    finish_load();
    fetch_exp(BASE,          {1'b0, 32'h0000_0062});
    fetch_exp(BASE + 64'd4,  {1'b0, NOP});
    drain();

    // Full memory without load_last.
    do_reset();
    stim.delete();
    for (int i = 0; i < 4 * DEPTH; i++) stim.push_back(8'(i));
    load_seq(1'b0, 1'b0);
    finish_load();
    fetch(BASE + 64'h0F8);
    fetch_exp(BASE,         {1'b0, 32'h0302_0100});
    fetch_exp(BASE + 64'd4, {1'b0, 32'h0706_0504});
    fetch(BASE + 64'h0FC);
    drain();

    // Reset mid-word discards the partial bytes.
    do_reset();
    stim = '{8'hAA, 8'hBB};
    load_seq(1'b0, 1'b0);
    do_reset();
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_seq(1'b1, 1'b0);
    finish_load();
    fetch_exp(BASE, {1'b0, 32'h4433_2211});
    fetch(BASE + 64'd4);
    drain();

    // Randomized loads and fetches.
    for (int r = 0; r < 6; r++) begin
      int n;
      bit lst;
      do_reset();
      n = $urandom_range(1, 4 * DEPTH);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      lst = (n < 4 * DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      load_seq(lst, 1'b1);
      finish_load();
      for (int f = 0; f < 30; f++) begin
        if ($urandom_range(0, 3) == 0) tick();
        fetch(rand_pc());
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
